// File: rtl/blink_pkg.sv
// Shared types and constants for the LED blinker and its receive-side monitor.
//   blink_mon_state_t : monitor FSM states
//   exp_half_per()    : expected half-period (2^cbits clocks) of the blinker
//   DEF_*             : default parameters shared with the blinker testbench
package blink_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } blink_mon_state_t;

    localparam int unsigned DEF_CBITS    = 24;
    localparam int unsigned DEF_TOL      = 2;
    localparam int unsigned DEF_LOCK_CNT = 2;

    // Half-period of a blinker that toggles once per wrap of a cbits-wide counter.
    function automatic logic [63:0] exp_half_per(input int unsigned cbits);
        return 64'd1 << cbits;
    endfunction

endpackage

// File: rtl/blink_edge_timer.sv
// Edge detector and run-length counter for the blink line.
//   clk, rst : clock, async active-low reset
//   led      : blink line, already synchronous to clk
//   ev_c     : combinational edge event (led differs from last sampled value)
//   rc       : clocks since the last edge; reads as the half-period on an edge
module blink_edge_timer #(
    parameter int unsigned CBITS = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             led,
    output logic             ev_c,
    output logic [CBITS+1:0] rc
);

    localparam int unsigned W = CBITS + 2;

    logic led_q;

    assign ev_c = led ^ led_q;

    // rc restarts at 1 on an edge so its value at the next edge is the length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q <= 1'b0;
            rc    <= '0;
        end else begin
            led_q <= led;
            if (ev_c) begin
                rc <= W'(1);
            end else if (rc != '1) begin
                rc <= rc + W'(1);
            end
        end
    end

endmodule

// File: rtl/blink_monitor.sv
// Receive-side checker for the counter-based LED blinker.
//   clk, rst : clock, async active-low reset
//   led      : blink line from the blinker
//   edge_p   : one-cycle pulse per level change of led
//   half_per : last measured half-period in clocks (held between edges)
//   per_vld  : one-cycle pulse when half_per is updated
//   locked   : high while LOCK_CNT consecutive half-periods were in tolerance
//   err      : one-cycle pulse on an out-of-tolerance period or a lost signal
module blink_monitor
    import blink_pkg::*;
#(
    parameter int unsigned CBITS    = DEF_CBITS,
    parameter int unsigned TOL      = DEF_TOL,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             led,
    output logic             edge_p,
    output logic [CBITS+1:0] half_per,
    output logic             per_vld,
    output logic             locked,
    output logic             err
);

    localparam int unsigned W  = CBITS + 2;
    localparam int unsigned GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [W-1:0] EXP = W'(exp_half_per(CBITS));
    localparam logic [W-1:0] LO  = EXP - W'(TOL);
    localparam logic [W-1:0] HI  = EXP + W'(TOL);
    localparam logic [W-1:0] TMO = HI + W'(1);

    localparam logic [GW-1:0] GMAX = GW'(LOCK_CNT);
    localparam logic [GW-1:0] GTHR = GW'(LOCK_CNT - 1);

    // Tolerance must leave a non-empty, non-wrapping good window.
    if ((64'(TOL) >= exp_half_per(CBITS)) || (LOCK_CNT == 0) || (CBITS > 60)) begin : g_param_check
        $error("blink_monitor: need TOL < 2**CBITS, LOCK_CNT >= 1, CBITS <= 60");
    end

    blink_mon_state_t state;
    logic [GW-1:0]    gc;
    logic             ev_c;
    logic [W-1:0]     rc;
    logic             good_c;
    logic             tmo_c;
    logic             reach_c;

    blink_edge_timer #(
        .CBITS (CBITS)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .led  (led),
        .ev_c (ev_c),
        .rc   (rc)
    );

    assign good_c  = (rc >= LO) && (rc <= HI);
    assign tmo_c   = (rc == TMO);
    assign reach_c = (gc >= GTHR);

    // State, good-count and all outputs; an edge always takes priority over timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= SEARCH;
            gc       <= '0;
            edge_p   <= 1'b0;
            half_per <= '0;
            per_vld  <= 1'b0;
            locked   <= 1'b0;
            err      <= 1'b0;
        end else begin
            edge_p  <= 1'b0;
            per_vld <= 1'b0;
            err     <= 1'b0;
            case (state)
                SEARCH: begin
                    locked <= 1'b0;
                    if (ev_c) begin
                        state  <= MEASURE;
                        gc     <= '0;
                        edge_p <= 1'b1;
                    end
                end
                MEASURE, LOCKED: begin
                    if (ev_c) begin
                        edge_p   <= 1'b1;
                        per_vld  <= 1'b1;
                        half_per <= rc;
                        if (good_c) begin
                            gc <= reach_c ? GMAX : gc + GW'(1);
                            if (reach_c) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            // Bad edge becomes the new reference.
                            err    <= 1'b1;
                            gc     <= '0;
                            state  <= MEASURE;
                            locked <= 1'b0;
                        end
                    end else if (tmo_c) begin
                        err    <= 1'b1;
                        gc     <= '0;
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    gc     <= '0;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_monitor.sv
module tb_blink_monitor;

    localparam int unsigned CBITS    = 4;
    localparam int unsigned TOL      = 2;
    localparam int unsigned LOCK_CNT = 2;
    localparam int          EXP      = 16;

    logic             clk;
    logic             rst;
    logic             led;
    logic             tb_led;
    logic             blk_led;
    logic [3:0]       blk_cnt;
    logic             use_blk;
    logic             edge_p;
    logic [CBITS+1:0] half_per;
    logic             per_vld;
    logic             locked;
    logic             err;

    int tests;
    int fails;

    blink_monitor #(
        .CBITS    (CBITS),
        .TOL      (TOL),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .led      (led),
        .edge_p   (edge_p),
        .half_per (half_per),
        .per_vld  (per_vld),
        .locked   (locked),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign led = use_blk ? blk_led : tb_led;

    // Reference blinker: toggles every time the 4-bit counter wraps.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_cnt <= 4'd0;
            blk_led <= 1'b0;
        end else begin
            blk_cnt <= blk_cnt + 4'd1;
            if (blk_cnt == 4'hF) blk_led <= ~blk_led;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks edge times by cycle number and applies the rules directly.
    int  m_cyc, m_last, m_good, len;
    bit  m_prev, m_ref, m_lock;
    bit  e_edge, e_vld, e_err;
    int  e_half;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cyc = 0; m_last = 0; m_good = 0;
            m_prev = 0; m_ref = 0; m_lock = 0;
            e_edge = 0; e_vld = 0; e_err = 0; e_half = 0;
        end else begin
            m_cyc++;
            e_edge = 0; e_vld = 0; e_err = 0;
            if (led != m_prev) begin
                m_prev = led;
                e_edge = 1;
                if (m_ref) begin
                    len    = m_cyc - m_last;
                    e_vld  = 1;
                    e_half = len;
                    if (len >= EXP - TOL && len <= EXP + TOL) begin
                        m_good++;
                        if (m_good >= LOCK_CNT) begin
                            m_good = LOCK_CNT;
                            m_lock = 1;
                        end
                    end else begin
                        e_err = 1; m_good = 0; m_lock = 0;
                    end
                end else begin
                    m_ref = 1; m_good = 0; m_lock = 0;
                end
                m_last = m_cyc;
            end else if (m_ref && (m_cyc - m_last) == EXP + TOL + 1) begin
                e_err = 1; m_ref = 0; m_good = 0; m_lock = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("edge_p",   int'(edge_p),   int'(e_edge));
            chk("per_vld",  int'(per_vld),  int'(e_vld));
            chk("half_per", int'(half_per), e_half);
            chk("locked",   int'(locked),   int'(m_lock));
            chk("err",      int'(err),      int'(e_err));
        end
    end

    bit s_edge, s_vld, s_lock, s_err;
    int s_half;

    // Wait n-1 clocks, toggle led (making a half-period of n), snapshot the edge response.
    task automatic half(input int n);
        repeat (n - 1) @(negedge clk);
        tb_led = ~tb_led;
        @(negedge clk);
        s_edge = edge_p; s_vld = per_vld; s_lock = locked; s_err = err; s_half = int'(half_per);
    endtask

    task automatic first_scenario(input string tag);
        half(1);
        chk({tag, "_e1_edge"}, int'(s_edge), 1);
        chk({tag, "_e1_vld"},  int'(s_vld),  0);
        half(16);
        chk({tag, "_e2_vld"},  int'(s_vld),  1);
        chk({tag, "_e2_half"}, s_half,       16);
        chk({tag, "_e2_lock"}, int'(s_lock), 0);
        half(16);
        chk({tag, "_e3_lock"}, int'(s_lock), 1);
        chk({tag, "_e3_err"},  int'(s_err),  0);
    endtask

    int n_err, first_err, n_edge, lock_edge;

    initial begin
        tests = 0; fails = 0;
        rst = 1'b0; tb_led = 1'b0; use_blk = 1'b0;
        #1;
        chk("rst_edge_p", int'(edge_p), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_half",   int'(half_per), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Clean 16-clock blinking from reset.
        first_scenario("s1");
        half(16);

        // Short period, then relock.
        half(13);
        chk("short_err",  int'(s_err),  1);
        chk("short_half", s_half,       13);
        chk("short_lock", int'(s_lock), 0);
        half(16);
        chk("re1_lock", int'(s_lock), 0);
        half(16);
        chk("re2_lock", int'(s_lock), 1);

        // Tolerance boundaries.
        half(14);
        chk("b14_lock", int'(s_lock), 1);
        half(18);
        chk("b18_lock", int'(s_lock), 1);
        chk("b18_err",  int'(s_err),  0);
        half(19);
        chk("b19_err",  int'(s_err),  1);
        chk("b19_lock", int'(s_lock), 0);
        half(16);
        half(16);
        chk("b_relock", int'(s_lock), 1);
        half(13);
        chk("b13_err",  int'(s_err),  1);
        half(16);
        half(16);
        chk("b_relock2", int'(s_lock), 1);

        // Lost signal: single timeout at rc == 19.
        n_err = 0; first_err = 0;
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk);
            if (err) begin
                n_err++;
                if (first_err == 0) first_err = i;
            end
        end
        chk("tmo_count", n_err,     1);
        chk("tmo_at",    first_err, 19);
        chk("tmo_lock",  int'(locked), 0);
        half(5);
        chk("search_edge", int'(s_edge), 1);
        chk("search_vld",  int'(s_vld),  0);
        chk("search_err",  int'(s_err),  0);
        half(16);
        half(16);
        chk("tmo_relock", int'(s_lock), 1);

        // Edge coincident with the timeout threshold.
        half(19);
        chk("coin_err",  int'(s_err),  1);
        chk("coin_half", s_half,       19);
        half(16);
        chk("coin_measure_vld", int'(s_vld), 1);
        chk("coin_measure_err", int'(s_err), 0);
        half(16);
        chk("coin_relock", int'(s_lock), 1);

        // Asynchronous reset mid-lock, between clock edges.
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_edge_p", int'(edge_p),   0);
        chk("arst_vld",    int'(per_vld),  0);
        chk("arst_half",   int'(half_per), 0);
        chk("arst_locked", int'(locked),   0);
        chk("arst_err",    int'(err),      0);
        tb_led = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        first_scenario("s6");

        // Driven by the reference blinker.
        rst = 1'b0;
        use_blk = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n_err = 0; n_edge = 0; lock_edge = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (edge_p) n_edge++;
            if (locked && lock_edge == 0) lock_edge = n_edge;
            if (err) n_err++;
        end
        chk("blk_err_count", n_err,        0);
        chk("blk_lock_edge", lock_edge,    3);
        chk("blk_locked",    int'(locked), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
